// File: rtl/poly_datapath_pkg.sv
// Shared definitions for the Horner polynomial datapath: FSM encoding,
// add/subtract mode constants and default widths.
package poly_datapath_pkg;

  localparam int W_DEF  = 16;
  localparam int XW_DEF = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // LOAD is part of the encoding but the latency budget leaves no edge for
  // it: IDLE loads the operands itself and jumps straight to MUL1.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL1 = 3'd2,
    ADDB = 3'd3,
    MUL2 = 3'd4,
    ADDC = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/poly_datapath_ula_param.sv
// W-bit adder/subtractor. co is the carry-out when adding and the borrow
// when subtracting (a < b).
module ula_param #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         co
);

  logic [W:0] sum_s;

  // One extra MSB captures carry (add) or borrow (subtract)
  always_comb begin
    sum_s = {(W+1){1'b0}};
    if (sub) begin
      sum_s = {1'b0, a} - {1'b0, b};
    end else begin
      sum_s = {1'b0, a} + {1'b0, b};
    end
  end

  assign y  = sum_s[W-1:0];
  assign co = sum_s[W];

endmodule

// File: rtl/poly_datapath.sv
// Evaluates (A*X +/- B)*X +/- C mod 2^W with a shift-add multiplier that
// processes X MSB-first, sharing one adder/subtractor between the multiply
// steps and the coefficient steps. Overflow is sticky per evaluation.
module poly_datapath
  import poly_datapath_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int XW = XW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          sel_sub,
  input  logic [XW-1:0] X,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [W-1:0]  C,
  output logic          busy,
  output logic          done,
  output logic          Overflow,
  output logic [W-1:0]  Resultado
);

  localparam int CW = $clog2(XW + 1);

  state_t        state_r, state_nxt_s;
  logic [XW-1:0] rx_r;
  logic [W-1:0]  rs_r, rh_r, rb_r, rc_r;
  logic          rm_r;
  logic [CW-1:0] cnt_r;
  logic          ov_r, busy_r, done_r;

  logic [XW-1:0] bit_mask_s;
  logic          mul_bit_s, last_step_s;
  logic [W-1:0]  alu_a_s, alu_b_s, alu_y_s;
  logic          alu_sub_s, alu_co_s;
  logic          load_s, rs_en_s, rh_en_s, cnt_clr_s, cnt_inc_s, ov_set_s;
  logic [W-1:0]  rs_d_s, rh_d_s;

  // Bit of X consumed this step: mask walks from MSB down as CNT grows
  assign bit_mask_s  = {1'b1, {(XW-1){1'b0}}} >> cnt_r;
  assign mul_bit_s   = |(rx_r & bit_mask_s);
  assign last_step_s = (cnt_r == CW'(XW - 1));

  ula_param #(.W(W)) u_ula (
    .a   (alu_a_s),
    .b   (alu_b_s),
    .sub (alu_sub_s),
    .y   (alu_y_s),
    .co  (alu_co_s)
  );

  // Next-state decode, ALU operand mux and register enables
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    rs_en_s     = 1'b0;
    rh_en_s     = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    ov_set_s    = 1'b0;
    rs_d_s      = {W{1'b0}};
    rh_d_s      = {W{1'b0}};
    alu_a_s     = rs_r;
    alu_b_s     = {W{1'b0}};
    alu_sub_s   = MODE_ADD;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = MUL1;
          load_s      = 1'b1;
          rs_en_s     = 1'b1;
          rh_en_s     = 1'b1;
          rh_d_s      = A;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL1, MUL2: begin
        // RS <- (RS<<1) + bit*RH; the dropped MSB and the carry both overflow
        alu_a_s   = {rs_r[W-2:0], 1'b0};
        alu_b_s   = mul_bit_s ? rh_r : {W{1'b0}};
        alu_sub_s = MODE_ADD;
        rs_en_s   = 1'b1;
        rs_d_s    = alu_y_s;
        cnt_inc_s = 1'b1;
        ov_set_s  = rs_r[W-1] | alu_co_s;
        if (last_step_s) begin
          state_nxt_s = (state_r == MUL1) ? ADDB : ADDC;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ADDB: begin
        // Inner Horner term becomes the multiplicand for the second pass
        alu_b_s     = rb_r;
        alu_sub_s   = rm_r;
        rh_en_s     = 1'b1;
        rh_d_s      = alu_y_s;
        rs_en_s     = 1'b1;
        cnt_clr_s   = 1'b1;
        ov_set_s    = alu_co_s;
        state_nxt_s = MUL2;
      end
      ADDC: begin
        alu_b_s     = rc_r;
        alu_sub_s   = rm_r;
        rs_en_s     = 1'b1;
        rs_d_s      = alu_y_s;
        ov_set_s    = alu_co_s;
        state_nxt_s = DONE;
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture at accept time so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_r <= {XW{1'b0}};
      rb_r <= {W{1'b0}};
      rc_r <= {W{1'b0}};
      rm_r <= 1'b0;
    end else if (load_s) begin
      rx_r <= X;
      rb_r <= B;
      rc_r <= C;
      rm_r <= sel_sub;
    end
  end

  // Accumulator RS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_r <= {W{1'b0}};
    end else if (rs_en_s) begin
      rs_r <= rs_d_s;
    end
  end

  // Multiplicand RH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rh_r <= {W{1'b0}};
    end else if (rh_en_s) begin
      rh_r <= rh_d_s;
    end
  end

  // Step counter for the multiply passes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Sticky overflow, cleared only when a new evaluation is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_r <= 1'b0;
    end else if (load_s) begin
      ov_r <= 1'b0;
    end else if (ov_set_s) begin
      ov_r <= 1'b1;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign Overflow  = ov_r;
  assign Resultado = rs_r;

endmodule

// File: tb/tb_poly_datapath.sv
// Self-checking bench for poly_datapath (W=16, XW=8): directed vectors,
// randomized operands against an arithmetic reference model, busy-time
// interference, mid-evaluation reset and back-to-back operation.
module tb_poly_datapath;

  localparam int TW  = 16;
  localparam int TXW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            sel_sub;
  logic [TXW-1:0]  X;
  logic [TW-1:0]   A, B, C;
  logic            busy, done, Overflow;
  logic [TW-1:0]   Resultado;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int done_cnt = 0;

  poly_datapath #(.W(TW), .XW(TXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sel_sub   (sel_sub),
    .X         (X),
    .A         (A),
    .B         (B),
    .C         (C),
    .busy      (busy),
    .done      (done),
    .Overflow  (Overflow),
    .Resultado (Resultado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic of the polynomial, flagging any
  // intermediate result that leaves [0, 2^W).
  function automatic void ref_eval(input longint unsigned x, input longint unsigned a,
                                   input longint unsigned b, input longint unsigned c,
                                   input bit s, output logic [TW-1:0] r, output logic ov);
    longint unsigned m, p, h, q, t;
    m  = 64'd1 << TW;
    ov = 1'b0;
    p  = a * x;
    if (p >= m) ov = 1'b1;
    p = p % m;
    if (s) begin
      if (p < b) ov = 1'b1;
      h = (p + m - b) % m;
    end else begin
      h = p + b;
      if (h >= m) ov = 1'b1;
      h = h % m;
    end
    q = h * x;
    if (q >= m) ov = 1'b1;
    q = q % m;
    if (s) begin
      if (q < c) ov = 1'b1;
      t = (q + m - c) % m;
    end else begin
      t = q + c;
      if (t >= m) ov = 1'b1;
      t = t % m;
    end
    r = t[TW-1:0];
  endfunction

  // One full evaluation; optionally scrambles operands and pulses start
  // while busy. Returns observed result/overflow for literal checks.
  task automatic run_eval(input string tag, input logic [TXW-1:0] x, input logic [TW-1:0] a,
                          input logic [TW-1:0] b, input logic [TW-1:0] c, input logic s,
                          input bit scramble, output logic [TW-1:0] res, output logic ov);
    logic [TW-1:0] er;
    logic          eo;
    int            edges;
    bit            seen;
    ref_eval(x, a, b, c, s, er, eo);
    @(negedge clk);
    X = x; A = a; B = b; C = c; sel_sub = s; start = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      edges++;
      if (edges == 1) chk({tag, "_busy_edge1"}, busy, 1);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else if (scramble && edges < 16) begin
        X = TXW'($urandom); A = TW'($urandom); B = TW'($urandom); C = TW'($urandom);
        sel_sub = 1'($urandom); start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    res = Resultado;
    ov  = Overflow;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, edges, 19);
    chk({tag, "_result"}, Resultado, er);
    chk({tag, "_overflow"}, Overflow, eo);
    chk({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_done_pulse1"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    @(negedge clk);
    chk({tag, "_result_hold"}, Resultado, er);
    chk({tag, "_ov_hold"}, Overflow, eo);
    chk({tag, "_idle_stays"}, busy, 0);
  endtask

  task automatic wait_done(output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t  = edge_cnt;
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [TW-1:0] r, er;
    logic          o, eo;
    int            t0, t1, t2, d0;
    bit            ok;

    rst_n = 1'b0; start = 1'b0; sel_sub = 1'b0;
    X = '0; A = '0; B = '0; C = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ov", Overflow, 0);
    chk("rst_res", Resultado, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with literal expectations
    run_eval("v030", 8'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b0, r, o);
    chk("v030_lit_res", r, 16'h0019);
    chk("v030_lit_ov", o, 0);
    run_eval("v031a", 8'd3, 16'd2, 16'd1, 16'd4, 1'b1, 1'b0, r, o);
    chk("v031a_lit_res", r, 16'd11);
    chk("v031a_lit_ov", o, 0);
    run_eval("v031b", 8'd1, 16'd1, 16'd5, 16'd0, 1'b1, 1'b0, r, o);
    chk("v031b_lit_res", r, 16'hFFFC);
    chk("v031b_lit_ov", o, 1);
    run_eval("v032a", 8'd255, 16'd255, 16'd0, 16'd0, 1'b0, 1'b0, r, o);
    chk("v032a_lit_res", r, 16'h02FF);
    chk("v032a_lit_ov", o, 1);
    run_eval("v032b", 8'd0, 16'hFFFF, 16'h1234, 16'd7, 1'b0, 1'b0, r, o);
    chk("v032b_lit_res", r, 16'd7);
    chk("v032b_lit_ov", o, 0);
    run_eval("xzero_sub", 8'd0, 16'h00AA, 16'd0, 16'd3, 1'b1, 1'b0, r, o);
    chk("xzero_sub_lit", r, 16'hFFFD);

    // Busy-time interference: operands and start toggled after edge 1
    run_eval("v034_busy", 8'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b1, r, o);
    chk("v034_busy_lit", r, 16'h0019);

    // Randomized operands, half with interference
    for (int i = 0; i < 10; i++) begin
      run_eval($sformatf("rnd%0d", i), TXW'($urandom), TW'($urandom), TW'($urandom),
               TW'($urandom), 1'($urandom), bit'(i % 2), r, o);
    end
    // Small operands that stay in range for a non-overflow random case
    run_eval("rnd_small", TXW'($urandom_range(1, 15)), TW'($urandom_range(0, 15)),
             TW'($urandom_range(0, 15)), TW'($urandom_range(0, 15)), 1'b0, 1'b0, r, o);
    chk("rnd_small_ov", o, 0);

    // Reset asserted between edges 10 and 11 of an evaluation
    @(negedge clk);
    X = 8'd1; A = 16'd1; B = 16'd5; C = 16'd0; sel_sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("abort_ov_before", Overflow, 1);
    chk("abort_busy_before", busy, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ov", Overflow, 0);
    chk("abort_res", Resultado, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);
    run_eval("after_abort", 8'd3, 16'd2, 16'd1, 16'd4, 1'b1, 1'b0, r, o);
    chk("after_abort_lit", r, 16'd11);

    // start held high: back-to-back evaluations
    ref_eval(64'd7, 64'd9, 64'd11, 64'd13, 1'b0, er, eo);
    @(negedge clk);
    X = 8'd7; A = 16'd9; B = 16'd11; C = 16'd13; sel_sub = 1'b0; start = 1'b1;
    t0 = edge_cnt;
    wait_done(t1, ok);
    chk("b2b_first_seen", ok, 1);
    chk("b2b_first_latency", t1 - t0, 19);
    chk("b2b_first_res", Resultado, er);
    wait_done(t2, ok);
    start = 1'b0;
    chk("b2b_second_seen", ok, 1);
    chk("b2b_spacing", t2 - t1, 20);
    chk("b2b_second_res", Resultado, er);
    chk("b2b_second_ov", Overflow, eo);
    repeat (3) @(negedge clk);
    chk("b2b_stops", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/poly_datapath.md
POLY_DATAPATH -- requirements
Module: poly_datapath

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand, accumulator and result width in bits.
REQ-002 The block SHALL have parameter XW, default 8, giving the X operand width in bits; legal range 2..W.
REQ-003 Port clk  input  1  -- single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  -- reset, asynchronous, active-low.
REQ-005 Port start  input  1  -- request; sampled only in IDLE.
REQ-006 Port sel_sub  input  1  -- mode, sampled with start: 0 = add B/C terms, 1 = subtract them.
REQ-007 Port X  input  XW  -- evaluation point, unsigned.
REQ-008 Ports A, B, C  input  W each  -- coefficients, unsigned.
REQ-009 Port busy  output  1  -- high in every state except IDLE.
REQ-010 Port done  output  1  -- one-cycle pulse; Resultado is final.
REQ-011 Port Overflow  output  1  -- sticky flag for the current evaluation.
REQ-012 Port Resultado  output  W  -- accumulator register RS, driven directly.

Function
REQ-013 The block SHALL compute Resultado = (A*X ± B)*X ± C (Horner form of A*X^2 ± B*X ± C), modulo 2^W.
REQ-014 FSM states SHALL be IDLE, LOAD, MUL1, ADDB, MUL2, ADDC, DONE.
REQ-015 IDLE with start=1 at an edge SHALL latch X→RX, A→RH and sel_sub→RM, clear RS and Overflow, zero counter CNT, and enter MUL1; this is edge 1.
REQ-016 MUL1/MUL2 SHALL run exactly XW edges, MSB-first: each edge does RS ← (RS<<1) + (RX[XW-1-CNT] ? RH : 0), then CNT increments.
REQ-017 After the XW-th MUL1 edge the next edge (ADDB) SHALL do RH ← RS ± B and RS ← 0, then CNT ← 0 and enter MUL2.
REQ-018 After the XW-th MUL2 edge the next edge (ADDC) SHALL do RS ← RS ± C and enter DONE.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE on the next edge; total start-to-done latency SHALL be 2*XW+3 edges (19 for XW=8).
REQ-020 Overflow SHALL be set, and stay set until the next accepted start, when any of these occur:
- a shift drops a 1 from bit W-1;
- an addition carries out of bit W-1;
- a subtraction borrows.
REQ-021 Resultado and Overflow SHALL hold their final values in IDLE until the next accepted start; intermediate values are visible while busy.
REQ-022 start SHALL be ignored while busy=1; operand and sel_sub changes after edge 1 SHALL have no effect.
REQ-023 X=0 SHALL yield Resultado = ±C mod 2^W after full latency, with no early exit.
REQ-024 start held high continuously SHALL restart one edge after DONE, i.e. the first IDLE edge.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, regardless of the current state, including mid-evaluation:
- state IDLE;
- RX, RS, RH, RM and CNT to 0;
- busy, done and Overflow to 0;
- Resultado to 0.
REQ-026 After rst_n rises, the first edge SHALL behave as IDLE; an aborted evaluation SHALL never produce done.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the mode constants (ADD=0, SUB=1), and the W/XW defaults.
REQ-028 One sub-module, ula_param, SHALL be instantiated.
- Function: W-bit add/subtract with a carry/borrow output.
- Use: shared by the multiply-step and coefficient-step additions.
REQ-029 Registers RX, RS and RH SHALL be plain enable-loaded registers with async clear; the operand selection feeding ula_param SHALL be a mux controlled by the FSM.

Verification
REQ-030 W=16, XW=8, sel_sub=0, X=2, A=3, B=4, C=5, start pulse → done at edge 19 with Resultado=25 (0x0019), Overflow=0, busy low after done.
REQ-031 sel_sub=1, X=3, A=2, B=1, C=4 → Resultado=11, Overflow=0; sel_sub=1, X=1, A=1, B=5, C=0 → Resultado=0xFFFC, Overflow=1.
REQ-032 X=255, A=255, B=0, C=0, sel_sub=0 → Overflow=1, Resultado=0x02FF (255^3 mod 2^16); X=0, A=0xFFFF, C=7 → Resultado=7, Overflow=0.
REQ-033 rst_n=0 at edge 10 of an evaluation → busy, done, Overflow and Resultado read 0 at once, and done never pulses; a new start then completes normally.
REQ-034 start re-pulsed with different operands at edge 5 → ignored, first result unchanged; start held high → back-to-back evaluations with done pulses 20 edges apart.
